note_envelope: RTL and testbench



---
 rtl/note_envelope.sv | 112 +++++++++++
 tb/tb_note_envelope.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/note_envelope.sv
// ADSR amplitude envelope: scales an offset-binary sample around 128 by an envelope level.
// sample_out is registered one cycle after sample_in; no flow control, one sample per cycle.
module note_envelope #(
  parameter int unsigned TICK_DIV      = 4096,
  parameter int unsigned ATTACK_STEP   = 16,
  parameter int unsigned DECAY_STEP    = 1,
  parameter int unsigned SUSTAIN_LEVEL = 160,
  parameter int unsigned RELEASE_STEP  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sample_in,
  input  logic       trigger,
  input  logic       gate,
  output logic [7:0] sample_out,
  output logic [7:0] level,
  output logic [2:0] env_state
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick;
  logic [9:0]    lvl10;
  logic [9:0]    atk_sum;

  assign tick    = (cnt_q == CNT_MAX);
  assign lvl10   = {2'b00, level_q};
  assign atk_sum = lvl10 + 10'(ATTACK_STEP);

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    cnt_d   = tick ? '0 : cnt_q + CW'(1);
    if (trigger) begin
      // Retrigger keeps the current level so the new attack starts without a click.
      state_d = S_ATTACK;
      cnt_d   = '0;
    end else if (tick) begin
      if (!gate && (state_q == S_ATTACK || state_q == S_DECAY || state_q == S_SUSTAIN)) begin
        state_d = S_RELEASE;
      end else begin
        case (state_q)
          S_ATTACK: begin
            if (atk_sum >= 10'd255) begin
              level_d = 8'd255;
              state_d = S_DECAY;
            end else begin
              level_d = atk_sum[7:0];
            end
          end
          S_DECAY: begin
            if (lvl10 <= 10'(SUSTAIN_LEVEL + DECAY_STEP)) begin
              level_d = 8'(SUSTAIN_LEVEL);
              state_d = S_SUSTAIN;
            end else begin
              level_d = level_q - 8'(DECAY_STEP);
            end
          end
          S_RELEASE: begin
            if (lvl10 <= 10'(RELEASE_STEP)) begin
              level_d = 8'd0;
              state_d = S_IDLE;
            end else begin
              level_d = level_q - 8'(RELEASE_STEP);
            end
          end
          S_IDLE:  level_d = 8'd0;
          default: level_d = level_q;
        endcase
      end
    end
  end

  // Signed product fits 17 bits; floor shift then re-bias to offset binary.
  logic signed [8:0]  s_centered;
  logic signed [16:0] prod;
  logic [7:0]         sample_d;

  assign s_centered = $signed({1'b0, sample_in}) - 9'sd128;
  assign prod       = 17'(s_centered) * 17'($signed({1'b0, level_q}));
  assign sample_d   = 8'(prod >>> 8) + 8'd128;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      level_q    <= 8'd0;
      cnt_q      <= '0;
      sample_out <= 8'd128;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      cnt_q      <= cnt_d;
      sample_out <= sample_d;
    end
  end

  assign level     = level_q;
  assign env_state = state_q;

endmodule

// File: tb/tb_note_envelope.sv
// Randomized scoreboard bench for note_envelope with an arithmetic ADSR reference model.
module tb_note_envelope;

  localparam int TD  = 4;
  localparam int ATK = 16;
  localparam int DEC = 1;
  localparam int SUS = 160;
  localparam int REL = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sample_in = 8'd0;
  logic       trigger = 1'b0;
  logic       gate = 1'b0;
  logic [7:0] sample_out;
  logic [7:0] level;
  logic [2:0] env_state;

  always #5 clk = ~clk;

  note_envelope #(
    .TICK_DIV(TD), .ATTACK_STEP(ATK), .DECAY_STEP(DEC),
    .SUSTAIN_LEVEL(SUS), .RELEASE_STEP(REL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .trigger(trigger), .gate(gate),
    .sample_out(sample_out), .level(level), .env_state(env_state)
  );

  typedef struct { int lvl; int st; int so; } exp_t;
  exp_t sb[$];
  int total = 0;
  int bad = 0;

  // Reference model: level/state, cycles since last trigger or reset, expected output sample.
  int m_level = 0;
  int m_state = 0;
  int m_cyc   = 0;
  int m_so    = 128;
  int dir_idx = 0;
  int dir_tab [5] = '{255, 0, 128, 228, 28};

  function automatic int floor_div256(int p);
    int r;
    r = p % 256;
    if (r < 0) r += 256;
    return (p - r) / 256;
  endfunction

  function automatic void model_step(bit r, bit t, bit g, int s);
    bit tk;
    if (!r) begin
      m_level = 0; m_state = 0; m_so = 128; m_cyc = 0;
      return;
    end
    m_so = (floor_div256((s - 128) * m_level) + 128) & 255;
    tk = ((m_cyc % TD) == TD - 1);
    if (t) begin
      m_state = 1;
      m_cyc   = 0;
      return;
    end
    m_cyc++;
    if (!tk) return;
    if (!g && (m_state == 1 || m_state == 2 || m_state == 3)) begin
      m_state = 4;
      return;
    end
    case (m_state)
      1: begin
        m_level = (m_level + ATK > 255) ? 255 : m_level + ATK;
        if (m_level == 255) m_state = 2;
      end
      2: begin
        m_level = (m_level - DEC < SUS) ? SUS : m_level - DEC;
        if (m_level == SUS) m_state = 3;
      end
      4: begin
        m_level = (m_level - REL < 0) ? 0 : m_level - REL;
        if (m_level == 0) m_state = 0;
      end
      default: ;
    endcase
  endfunction

  function automatic int pick_sample();
    if (m_level == 255 || m_level == SUS) begin
      dir_idx++;
      return dir_tab[dir_idx % 5];
    end
    return int'($urandom_range(0, 255));
  endfunction

  task automatic drive(input bit r, input bit t, input bit g, input int s);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r; trigger = t; gate = g; sample_in = 8'(s);
    model_step(r, t, g, s);
    e.lvl = m_level; e.st = m_state; e.so = m_so;
    sb.push_back(e);
  endtask

  task automatic run(input int n, input bit g);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, g, pick_sample());
  endtask

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      if (bad <= 20) $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: an entry pushed after edge N describes the outputs after edge N+1.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (sb.size() > 0) begin
        @(negedge clk);
        e = sb.pop_front();
        check("level", int'(level), e.lvl);
        check("env_state", int'(env_state), e.st);
        check("sample_out", int'(sample_out), e.so);
      end
    end
  end

  task automatic finish_run();
    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  initial begin
    #1_000_000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    bit g;
    // Reset with a non-midpoint sample, then idle with no trigger.
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 200);
    for (int i = 0; i < 100; i++) drive(1'b1, 1'b0, (i % 7) == 0, int'($urandom_range(0, 255)));

    // Attack to 255, decay to sustain, hold.
    drive(1'b1, 1'b1, 1'b1, pick_sample());
    run(64 + 95 * 4 + 20, 1'b1);

    // Release to idle.
    run(TD * 42 + 10, 1'b0);

    // Retrigger mid-release at level 80.
    drive(1'b1, 1'b1, 1'b1, pick_sample());
    for (int i = 0; i < 2000 && m_state != 3; i++) drive(1'b1, 1'b0, 1'b1, pick_sample());
    for (int i = 0; i < 2000 && !(m_state == 4 && m_level == 80); i++)
      drive(1'b1, 1'b0, 1'b0, pick_sample());
    drive(1'b1, 1'b1, 1'b1, pick_sample());
    run(10, 1'b1);
    drive(1'b1, 1'b1, 1'b0, pick_sample());
    run(12, 1'b0);
    for (int i = 0; i < 2000 && m_state != 0; i++) drive(1'b1, 1'b0, 1'b0, pick_sample());

    // Reset mid-attack at level 112.
    drive(1'b1, 1'b1, 1'b1, pick_sample());
    for (int i = 0; i < 500 && !(m_state == 1 && m_level == 112); i++)
      drive(1'b1, 1'b0, 1'b1, pick_sample());
    drive(1'b0, 1'b0, 1'b1, pick_sample());
    run(5, 1'b1);

    // Random triggers, gate changes and occasional resets.
    g = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) g = ~g;
      drive($urandom_range(0, 499) != 0, $urandom_range(0, 39) == 0, g, pick_sample());
    end

    finish_run();
  end

endmodule
